merge_sel_gen: RTL and testbench
================================

Name: merge_sel_gen

Overview:
- Clocked select-token sequencer that drives the select channel of the PE's two-input psum merge.
- Per output pixel, emits one "take fresh psum" token (sel=0, merge input L0), then N-1 "take feedback" tokens (sel=1, merge input L1).
- Configured per job by a round count and an accumulation length.
- Sits directly upstream of the merge select input, behind a clocked-to-CSP channel adapter.

Parameters:
- LEN_W, 8, width of the accumulation-length field; N ranges 0..2^LEN_W-1.
- RND_W, 8, width of the round-count field; R ranges 0..2^RND_W-1.

Ports:
- clk  input  1  single clock for the block.
- rst  input  1  reset, synchronous, active-high.
- cfg_valid  input  1  job configuration offered.
- cfg_ready  output  1  block can accept a job; high only in IDLE.
- cfg_len  input  LEN_W  accumulation length N per round.
- cfg_rounds  input  RND_W  number of rounds R.
- sel_valid  output  1  select token present.
- sel_ready  input  1  consumer accepts the token.
- sel  output  1  0 = take L0 (fresh), 1 = take L1 (feedback).
- sel_last  output  1  marks the final token of the current round.
- done  output  1  one-cycle pulse when the job completes.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; cfg_ready=1, sel_valid=0, sel=0, sel_last=0, done=0; all counters cleared.
- A reset asserted mid-job abandons the job immediately. No further tokens or done pulse are produced.
- All outputs are registered.
- A config handshake occurs at a posedge with cfg_valid && cfg_ready. cfg_len and cfg_rounds are latched on that edge.
- A token transfer occurs at a posedge with sel_valid && sel_ready.
- States:
  - IDLE: cfg_ready=1.
    - On config handshake with N>=1 and R>=1: go to EMIT. The first token (sel=0, sel_last=(N==1)) is valid on the cycle after the handshake edge, giving 1-cycle latency.
    - On config handshake with N==0 or R==0: go to FIN. No tokens are emitted.
  - EMIT: cfg_ready=0, sel_valid=1.
    - Token index k runs 0..N-1 within round r, which runs 0..R-1.
    - sel = (k!=0); sel_last = (k==N-1).
    - On each transfer, k advances. When k==N-1, k wraps to 0 and r advances.
    - The transfer of k==N-1 with r==R-1 goes to FIN. sel_valid drops the next cycle, with no bubble before it.
  - FIN: done=1 for exactly one cycle, sel_valid=0, cfg_ready=0, then IDLE.
- Throughput: one token per cycle while sel_ready is held high. There are no bubbles between rounds.
- Backpressure: while sel_valid && !sel_ready, sel and sel_last are held stable and counters do not advance.
- N==1: every token has sel=0 and sel_last=1.
- Maximum values (N=2^LEN_W-1, R=2^RND_W-1) must complete without counter overflow. Counters are exactly LEN_W and RND_W bits and compare before increment.
- A config offered while not IDLE is ignored, since cfg_ready=0. cfg_valid may stay high across a job without retriggering.
- A new config is accepted in the IDLE cycle that follows FIN. Minimum job-to-job gap is 2 cycles: the FIN cycle plus the IDLE accept cycle.

Decomposition:
- Shared package pe_pkg holds:
  - SEL_NEW=1'b0 and SEL_ACC=1'b1 constants, also used by the merge bench.
  - typedef enum logic [1:0] {IDLE, EMIT, FIN} msg_state_t.
  - Default LEN_W and RND_W values.
- No sub-module; the two counters are inline.

Test Plan:
- Basic job: reset, then config N=3, R=2 with sel_ready=1.
  - Required tokens, cycles 1-6 after accept: sel=0,1,1,0,1,1 and sel_last=0,0,1,0,0,1.
  - done pulses on cycle 7; cfg_ready returns to 1 on cycle 8.
- Backpressure: N=4, R=1 with sel_ready toggling 1,0,0,1,1,0,1.
  - Sequence 0,1,1,1 delivered exactly once each, with no duplicates or drops.
  - Outputs stable during stalls.
  - done pulses exactly 1 cycle after the 4th transfer.
- Zero and unit cases:
  - N=0, R=5: no sel_valid, done pulses 1 cycle after accept.
  - N=1, R=3: three tokens, each sel=0 and sel_last=1.
- Mid-job reset: N=8, R=4; assert rst for 1 cycle after 5 transfers.
  - Next cycle: sel_valid=0, cfg_ready=1, no done pulse.
  - A new job N=2, R=1 then yields 0,1 normally.
- Maximum and back-to-back: N=255, R=255 with sel_ready=1.
  - Exactly 65025 tokens and 255 sel_last pulses, followed by done.
  - cfg_valid held high throughout; the second job is accepted only in the IDLE cycle after done.
- Config ignored while busy: change cfg_len and cfg_rounds during EMIT with cfg_valid=1.
  - The running job is unaffected; the new values take effect only on the next IDLE handshake.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE definitions: merge select encodings, the select-sequencer state type
// and default counter widths.
package pe_pkg;

    localparam logic SEL_NEW = 1'b0;
    localparam logic SEL_ACC = 1'b1;

    localparam int DEF_LEN_W = 8;
    localparam int DEF_RND_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } msg_state_t;

endpackage

// File: rtl/merge_sel_gen_if.sv
// Job-configuration and select-token channels of the merge select sequencer.
// The master side is the sequencer; the slave side is its job source and token consumer.
interface merge_sel_gen_if #(
    parameter int LEN_W = pe_pkg::DEF_LEN_W,
    parameter int RND_W = pe_pkg::DEF_RND_W
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [LEN_W-1:0] cfg_len;
    logic [RND_W-1:0] cfg_rounds;
    logic             sel_valid;
    logic             sel_ready;
    logic             sel;
    logic             sel_last;
    logic             done;

    modport master (
        input  cfg_valid, cfg_len, cfg_rounds, sel_ready,
        output cfg_ready, sel_valid, sel, sel_last, done
    );

    modport slave (
        output cfg_valid, cfg_len, cfg_rounds, sel_ready,
        input  cfg_ready, sel_valid, sel, sel_last, done
    );
endinterface

// File: rtl/merge_sel_gen.sv
// Select-token sequencer for the psum merge: per pixel one fresh-psum token followed by
// N-1 feedback tokens, repeated for R rounds, then a one-cycle done pulse.
module merge_sel_gen
    import pe_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int RND_W = DEF_RND_W
) (
    input  logic            clk,
    input  logic            rst,
    merge_sel_gen_if.master bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [RND_W-1:0] RND_ONE = RND_W'(1);

    msg_state_t       state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [RND_W-1:0] rnd_reg;
    logic [LEN_W-1:0] k_reg;
    logic [RND_W-1:0] r_reg;
    logic             cfg_ready_reg;
    logic             sel_valid_reg;
    logic             sel_reg;
    logic             sel_last_reg;
    logic             done_reg;

    logic k_at_end;
    logic r_at_end;
    logic next_k_is_last;
    logic cfg_accept;
    logic sel_xfer;

    // Compare before increment so the maximum N and R never wrap the counters.
    assign k_at_end       = (k_reg == (len_reg - LEN_ONE));
    assign r_at_end       = (r_reg == (rnd_reg - RND_ONE));
    assign next_k_is_last = ((k_reg + LEN_ONE) == (len_reg - LEN_ONE));
    assign cfg_accept     = bus.cfg_valid && cfg_ready_reg;
    assign sel_xfer       = sel_valid_reg && bus.sel_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            rnd_reg       <= '0;
            k_reg         <= '0;
            r_reg         <= '0;
            cfg_ready_reg <= 1'b1;
            sel_valid_reg <= 1'b0;
            sel_reg       <= SEL_NEW;
            sel_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (cfg_accept) begin
                        len_reg       <= bus.cfg_len;
                        rnd_reg       <= bus.cfg_rounds;
                        k_reg         <= '0;
                        r_reg         <= '0;
                        cfg_ready_reg <= 1'b0;
                        if ((bus.cfg_len != '0) && (bus.cfg_rounds != '0)) begin
                            state_reg     <= EMIT;
                            sel_valid_reg <= 1'b1;
                            sel_reg       <= SEL_NEW;
                            sel_last_reg  <= (bus.cfg_len == LEN_ONE);
                        end else begin
                            // Empty job: skip straight to the completion pulse.
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (sel_xfer) begin
                        if (k_at_end) begin
                            k_reg <= '0;
                            if (r_at_end) begin
                                state_reg     <= FIN;
                                sel_valid_reg <= 1'b0;
                                sel_reg       <= SEL_NEW;
                                sel_last_reg  <= 1'b0;
                                done_reg      <= 1'b1;
                            end else begin
                                r_reg        <= r_reg + RND_ONE;
                                sel_reg      <= SEL_NEW;
                                sel_last_reg <= (len_reg == LEN_ONE);
                            end
                        end else begin
                            k_reg        <= k_reg + LEN_ONE;
                            sel_reg      <= SEL_ACC;
                            sel_last_reg <= next_k_is_last;
                        end
                    end
                end

                FIN: begin
                    state_reg     <= IDLE;
                    done_reg      <= 1'b0;
                    cfg_ready_reg <= 1'b1;
                end

                default: begin
                    state_reg     <= IDLE;
                    k_reg         <= '0;
                    r_reg         <= '0;
                    cfg_ready_reg <= 1'b1;
                    sel_valid_reg <= 1'b0;
                    sel_reg       <= SEL_NEW;
                    sel_last_reg  <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready = cfg_ready_reg;
    assign bus.sel_valid = sel_valid_reg;
    assign bus.sel       = sel_reg;
    assign bus.sel_last  = sel_last_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_merge_sel_gen.sv
// Self-checking bench for merge_sel_gen: table of jobs, hand sequences for reset and
// back-to-back jobs, and random jobs against a token-list reference model.
module tb_merge_sel_gen;
    import pe_pkg::*;

    localparam int LEN_W = 8;
    localparam int RND_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    merge_sel_gen_if #(.LEN_W(LEN_W), .RND_W(RND_W)) bus ();

    merge_sel_gen #(.LEN_W(LEN_W), .RND_W(RND_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int n;
        int r;
        int mode;
        int exp_tokens;
        int exp_lasts;
        int exp_done_cyc;
    } vec_t;

    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ready_for(input int mode, input int idx);
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[idx % 7];
        return 1'($urandom_range(0, 1));
    endfunction

    // Starts in an IDLE cycle, offers the job, follows it to done and ends in the next IDLE cycle.
    task automatic run_job(input int n, input int r, input int mode,
                           input bit chain, input int nn, input int nr,
                           output int tokens, output int lasts, output int done_cyc);
        bit exp_sel[$];
        bit exp_last[$];
        bit fin;
        bit expect_done;
        bit popped_last;
        int budget;
        tokens = 0;
        lasts = 0;
        done_cyc = -1;
        fin = 1'b0;
        popped_last = 1'b0;
        for (int rr = 0; rr < r; rr++)
            for (int kk = 0; kk < n; kk++) begin
                exp_sel.push_back(kk != 0);
                exp_last.push_back(kk == n - 1);
            end
        chk("cfg_ready_idle", int'(bus.cfg_ready), 1);
        bus.cfg_valid  = 1'b1;
        bus.cfg_len    = LEN_W'(n);
        bus.cfg_rounds = RND_W'(r);
        step();
        if (chain) begin
            bus.cfg_len    = LEN_W'(nn);
            bus.cfg_rounds = RND_W'(nr);
        end else begin
            bus.cfg_valid  = 1'b0;
            bus.cfg_len    = LEN_W'($urandom);
            bus.cfg_rounds = RND_W'($urandom);
        end
        budget = n * r * 8 + 20;
        for (int c = 1; c <= budget && !fin; c++) begin
            expect_done = popped_last;
            popped_last = 1'b0;
            if (c == 1) begin
                if (n == 0 || r == 0) chk("empty_job_done_latency", int'(bus.done), 1);
                else chk("first_token_latency", int'(bus.sel_valid), 1);
            end
            if (expect_done) chk("done_after_last_xfer", int'(bus.done), 1);
            if (bus.done) begin
                fin = 1'b1;
                done_cyc = c;
                chk("tokens_left_at_done", exp_sel.size(), 0);
                chk("sel_valid_at_done", int'(bus.sel_valid), 0);
                chk("cfg_ready_at_done", int'(bus.cfg_ready), 0);
            end else begin
                chk("cfg_ready_busy", int'(bus.cfg_ready), 0);
                if (!bus.sel_valid) begin
                    chk("sel_valid_in_job", int'(bus.sel_valid), 1);
                end else if (exp_sel.size() == 0) begin
                    chk("token_overrun", tokens + 1, n * r);
                end else begin
                    chk("sel", int'(bus.sel), int'(exp_sel[0]));
                    chk("sel_last", int'(bus.sel_last), int'(exp_last[0]));
                    bus.sel_ready = ready_for(mode, c - 1);
                    if (bus.sel_ready) begin
                        tokens++;
                        if (bus.sel_last) lasts++;
                        void'(exp_sel.pop_front());
                        void'(exp_last.pop_front());
                        if (exp_sel.size() == 0) popped_last = 1'b1;
                    end
                end
            end
            if (!fin) step();
        end
        chk("done_seen", int'(fin), 1);
        step();
        chk("done_one_cycle", int'(bus.done), 0);
        chk("cfg_ready_after_fin", int'(bus.cfg_ready), 1);
        $display("job n=%0d r=%0d mode=%0d tokens=%0d lasts=%0d done_cycle=%0d", n, r, mode, tokens, lasts, done_cyc);
    endtask

    vec_t vecs[8];
    int tk, ls, dc;

    initial begin
        vecs[0] = '{3, 2, 0, 6, 2, 7};
        vecs[1] = '{4, 1, 1, 4, 1, 8};
        vecs[2] = '{0, 5, 0, 0, 0, 1};
        vecs[3] = '{1, 3, 0, 3, 3, 4};
        vecs[4] = '{5, 0, 0, 0, 0, 1};
        vecs[5] = '{2, 3, 1, 6, 3, -1};
        vecs[6] = '{7, 2, 2, 14, 2, -1};
        vecs[7] = '{1, 1, 1, 1, 1, 2};

        rst = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_len    = '0;
        bus.cfg_rounds = '0;
        bus.sel_ready  = 1'b0;
        step();
        step();
        chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
        chk("rst_sel_valid", int'(bus.sel_valid), 0);
        chk("rst_sel", int'(bus.sel), 0);
        chk("rst_sel_last", int'(bus.sel_last), 0);
        chk("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_job(vecs[i].n, vecs[i].r, vecs[i].mode, 1'b0, 0, 0, tk, ls, dc);
            chk("vec_tokens", tk, vecs[i].exp_tokens);
            chk("vec_lasts", ls, vecs[i].exp_lasts);
            if (vecs[i].exp_done_cyc >= 0) chk("vec_done_cycle", dc, vecs[i].exp_done_cyc);
        end

        // Mid-job reset after five transfers.
        bus.cfg_valid  = 1'b1;
        bus.cfg_len    = 8'd8;
        bus.cfg_rounds = 8'd4;
        step();
        bus.cfg_valid = 1'b0;
        bus.sel_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("midrst_pre_sel_valid", int'(bus.sel_valid), 1);
        chk("midrst_pre_sel", int'(bus.sel), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_sel_valid", int'(bus.sel_valid), 0);
        chk("midrst_cfg_ready", int'(bus.cfg_ready), 1);
        chk("midrst_done", int'(bus.done), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_quiet_done", int'(bus.done), 0);
            chk("midrst_quiet_valid", int'(bus.sel_valid), 0);
        end
        run_job(2, 1, 0, 1'b0, 0, 0, tk, ls, dc);
        chk("after_rst_tokens", tk, 2);

        // Maximum job with cfg_valid held and new values offered while busy.
        run_job(255, 255, 0, 1'b1, 3, 2, tk, ls, dc);
        chk("max_tokens", tk, 65025);
        chk("max_lasts", ls, 255);
        run_job(3, 2, 0, 1'b0, 0, 0, tk, ls, dc);
        chk("chained_tokens", tk, 6);
        chk("chained_done_cycle", dc, 7);

        for (int i = 0; i < 20; i++) begin
            int n;
            int r;
            n = int'($urandom_range(0, 10));
            r = int'($urandom_range(0, 4));
            run_job(n, r, 2, 1'b0, 0, 0, tk, ls, dc);
            chk("rand_tokens", tk, n * r);
            chk("rand_lasts", ls, (n == 0) ? 0 : r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
